// File: rtl/dense_lanes.sv
// Multi-lane fully-connected layer: LANES neurons per pass over a streamed input vector,
// with bias, rounding, saturation and optional ReLU on the way to out_vec.
module dense_lanes #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int IN_DIM     = 1568,
    parameter int OUT_DIM    = 10,
    parameter int LANES      = 2,
    parameter int POST_SHIFT = 2,
    parameter bit ROUND_EN   = 1'b1,
    parameter bit RELU_EN    = 1'b0,
    // Weight ROM image, word o*IN_DIM+i at bits [(o*IN_DIM+i)*DATA_WIDTH +: DATA_WIDTH]
    parameter logic [OUT_DIM*IN_DIM*DATA_WIDTH-1:0] WEIGHTS_INIT = '0,
    parameter logic [OUT_DIM*DATA_WIDTH-1:0]        BIASES_INIT  = '0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    output logic [$clog2(IN_DIM)-1:0]            in_addr,
    output logic                                 in_en,
    input  logic signed [DATA_WIDTH-1:0]         in_q,
    output logic [OUT_DIM-1:0][DATA_WIDTH-1:0]   out_vec,
    output logic                                 busy,
    output logic                                 done
);
    localparam int AW   = $clog2(IN_DIM);
    localparam int G    = (OUT_DIM + LANES - 1) / LANES;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int ACCW = 2 * DATA_WIDTH + $clog2(IN_DIM);
    localparam int SH   = FRAC_BITS + POST_SHIFT;
    localparam logic [ACCW:0] RND = ROUND_EN ? ((ACCW + 1)'(1) << (SH - 1)) : '0;
    localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_WRITE, S_FINISH} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_in_addr;
    logic            r_in_en;
    logic            r_vld;
    logic [GW-1:0]   r_g;
    logic            r_busy;
    logic            r_done;
    logic            w_last_g;
    logic            w_load;
    logic signed [DATA_WIDTH-1:0] w_res [LANES];

    assign w_last_g = (r_g == GW'(G - 1));
    assign w_load   = ((r_state == S_IDLE) && start) || ((r_state == S_WRITE) && !w_last_g);
    assign in_addr  = r_in_addr;
    assign in_en    = r_in_en;
    assign busy     = r_busy;
    assign done     = r_done;

    // NOTE: sequential state uses <= so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_in_addr <= '0;
            r_in_en   <= 1'b0;
            r_vld     <= 1'b0;
            r_g       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_vld  <= r_in_en;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state   <= S_STREAM;
                    r_busy    <= 1'b1;
                    r_in_en   <= 1'b1;
                    r_in_addr <= '0;
                    r_g       <= '0;
                end
                S_STREAM: begin
                    if (r_in_addr == AW'(IN_DIM - 1)) begin
                        r_in_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_in_addr <= r_in_addr + AW'(1);
                    end
                end
                S_DRAIN: r_state <= S_WRITE;
                S_WRITE: begin
                    if (w_last_g) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_g       <= r_g + GW'(1);
                        r_in_en   <= 1'b1;
                        r_in_addr <= '0;
                        r_state   <= S_STREAM;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int                           w_n;
        int                           w_ln;
        logic signed [DATA_WIDTH-1:0] w_bias;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic signed [ACCW:0]         w_rnd;
        logic signed [ACCW:0]         w_sh;
        logic signed [DATA_WIDTH-1:0] w_lane_res;
        logic signed [DATA_WIDTH-1:0] r_wq;
        logic signed [ACCW-1:0]       r_acc;

        // Neuron in flight, and the neuron whose bias is loaded at the next group boundary.
        assign w_n    = int'(r_g) * LANES + l;
        assign w_ln   = ((r_state == S_IDLE) ? 0 : int'(r_g) + 1) * LANES + l;
        assign w_bias = (w_ln < OUT_DIM) ? BIASES_INIT[w_ln*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign w_prod = $signed({{DATA_WIDTH{in_q[DATA_WIDTH-1]}}, in_q})
                      * $signed({{DATA_WIDTH{r_wq[DATA_WIDTH-1]}}, r_wq});
        assign w_rnd  = {r_acc[ACCW-1], r_acc} + RND;
        assign w_sh   = w_rnd >>> SH;
        assign w_res[l] = w_lane_res;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wq  <= '0;
                r_acc <= '0;
            end else begin
                if (r_in_en) begin
                    r_wq <= (w_n < OUT_DIM)
                          ? WEIGHTS_INIT[(w_n*IN_DIM + int'(r_in_addr))*DATA_WIDTH +: DATA_WIDTH]
                          : '0;
                end
                if (w_load) begin
                    r_acc <= {{(ACCW - DATA_WIDTH){w_bias[DATA_WIDTH-1]}}, w_bias} <<< FRAC_BITS;
                end else if (r_vld) begin
                    r_acc <= r_acc + {{(ACCW - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
                end
            end
        end

        // NOTE: a default assignment first keeps this combinational block free of inferred latches.
        always_comb begin
            w_lane_res = w_sh[DATA_WIDTH-1:0];
            if (w_sh > SAT_MAX) begin
                w_lane_res = SAT_MAX[DATA_WIDTH-1:0];
            end else if (w_sh < SAT_MIN) begin
                w_lane_res = SAT_MIN[DATA_WIDTH-1:0];
            end
            if (RELU_EN && w_lane_res[DATA_WIDTH-1]) begin
                w_lane_res = '0;
            end
        end
    end

    // Only neurons of the current group are written; lanes past OUT_DIM have no target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vec <= '0;
        end else begin
            for (int n = 0; n < OUT_DIM; n++) begin
                if ((r_state == S_WRITE) && (r_g == GW'(n / LANES))) begin
                    out_vec[n] <= w_res[n % LANES];
                end
            end
        end
    end
endmodule

// File: tb/tb_dense_lanes.sv
// Directed bench: eight small dense_lanes configurations (IN_DIM=4, OUT_DIM=3) with
// hand-computed results, latency, start-while-busy and mid-run reset behaviour.
module tb_dense_lanes;
    localparam int NI = 8;

    localparam int L_T    [NI] = '{2, 2, 2, 2, 2, 2, 1, 3};
    localparam bit RND_T  [NI] = '{0, 0, 0, 0, 1, 0, 0, 0};
    localparam bit RELU_T [NI] = '{0, 0, 0, 1, 0, 0, 0, 0};
    localparam int T_T    [NI] = '{13, 13, 13, 13, 13, 13, 19, 7};
    localparam logic [191:0] W_T [NI] = '{
        {12{16'h0080}}, {12{16'h0080}},
        {{4{16'h0000}}, {4{16'h8001}}, {4{16'h7FFF}}},
        {{4{16'h0000}}, {4{16'h8001}}, {4{16'h7FFF}}},
        {12{16'h0040}}, {12{16'h0040}},
        {12{16'h0080}}, {12{16'h0080}}};
    localparam logic [47:0] B_T [NI] = '{
        48'h0, {16'h0000, 16'h0080, 16'h0000}, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
    localparam logic [63:0] X_T [NI] = '{
        {4{16'h0080}}, {4{16'h0080}}, {4{16'h7FFF}}, {4{16'h7FFF}},
        64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003, {4{16'h0080}}, {4{16'h0080}}};
    localparam logic [47:0] E_T [NI] = '{
        {3{16'h0200}}, {16'h0200, 16'h0280, 16'h0200},
        {16'h0000, 16'h8000, 16'h7FFF}, {16'h0000, 16'h0000, 16'h7FFF},
        {3{16'h0002}}, {3{16'h0001}}, {3{16'h0200}}, {3{16'h0200}}};

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NI-1:0]           start;
    logic [NI-1:0]           in_en;
    logic [NI-1:0]           busy;
    logic [NI-1:0]           done;
    logic [1:0]              in_addr [NI];
    logic signed [15:0]      in_q    [NI];
    logic [2:0][15:0]        out_vec [NI];
    int                      n_checks = 0;
    int                      n_fail   = 0;
    logic [1:0]              addr_log [$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        logic signed [15:0] r_q;
        dense_lanes #(
            .DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(4), .OUT_DIM(3), .LANES(L_T[k]),
            .POST_SHIFT(0), .ROUND_EN(RND_T[k]), .RELU_EN(RELU_T[k]),
            .WEIGHTS_INIT(W_T[k]), .BIASES_INIT(B_T[k])
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start[k]), .in_addr(in_addr[k]),
            .in_en(in_en[k]), .in_q(in_q[k]), .out_vec(out_vec[k]),
            .busy(busy[k]), .done(done[k])
        );
        // Input BRAM model: one-cycle read latency
        always @(posedge clk) if (in_en[k]) r_q <= X_T[k][in_addr[k]*16 +: 16];
        assign in_q[k] = r_q;
    end

    always @(posedge clk) if (in_en[1]) addr_log.push_back(in_addr[1]);

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse start, then count cycles to done; rep>=0 re-pulses start at that cycle.
    task automatic run(input int k, input int rep, output int cyc, output bit busy_ok);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (done[k] !== 1'b1 && cyc < 100) begin
            if (busy[k] !== 1'b1) busy_ok = 1'b0;
            start[k] = (cyc == rep);
            @(posedge clk); #1;
            cyc++;
        end
        start[k] = 1'b0;
    endtask

    task automatic run_and_check(input int k, input int rep, input string tag);
        int cyc;
        bit busy_ok;
        run(k, rep, cyc, busy_ok);
        check($sformatf("%s_latency%0d", tag, k), cyc, T_T[k]);
        check($sformatf("%s_busy%0d", tag, k), busy_ok, 1'b1);
        check($sformatf("%s_out%0d", tag, k), out_vec[k], E_T[k]);
        @(posedge clk); #1;
        check($sformatf("%s_donepulse%0d", tag, k), done[k], 1'b0);
    endtask

    initial begin
        int         extra;
        logic [15:0] addrs;
        reset_n = 1'b0;
        start   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_busy%0d", k), busy[k], 1'b0);
            check($sformatf("rst_done%0d", k), done[k], 1'b0);
            check($sformatf("rst_in_en%0d", k), in_en[k], 1'b0);
            check($sformatf("rst_in_addr%0d", k), in_addr[k], 2'd0);
            check($sformatf("rst_out%0d", k), out_vec[k], 48'h0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NI; k++) run_and_check(k, -1, "cfg");

        addrs = '0;
        for (int i = 0; i < addr_log.size() && i < 8; i++) addrs[i*2 +: 2] = addr_log[i];
        check("addr_count", addr_log.size(), 8);
        check("addr_sweep", addrs, 16'hE4E4);

        // start re-pulsed while busy must not restart or add a second done
        run_and_check(0, 3, "restart");
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) extra++;
        end
        check("no_extra_done", extra, 0);

        // Reset in the second group clears everything immediately
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_pre", busy[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy[0], 1'b0);
        check("mid_rst_in_en", in_en[0], 1'b0);
        check("mid_rst_in_addr", in_addr[0], 2'd0);
        check("mid_rst_out", out_vec[0], 48'h0);
        check("mid_rst_done", done[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_and_check(0, -1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
